// File: rtl/iecdrv_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous drive ROM between up to 4 drives, plus the image-loader write port.
// Optional: define IECDRV_ROM_HITCACHE_EN to answer repeated same-address reads without a ROM access.
module iecdrv_rom_arbiter #(
  parameter int NDRV    = 4,
  parameter int AW      = 15,
  parameter int ROM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NDRV-1:0]    req,
  input  logic [NDRV*AW-1:0] req_addr,
  output logic [NDRV*8-1:0]  rd_data,
  output logic [NDRV-1:0]    rd_valid,
  output logic [NDRV-1:0]    busy,
  input  logic               ld_wr,
  input  logic [AW-1:0]      ld_addr,
  input  logic [7:0]         ld_data,
  output logic [AW-1:0]      mem_addr,
  output logic               mem_we,
  output logic [7:0]         mem_d,
  input  logic [7:0]         mem_q
);

  // state  | meaning
  // S_IDLE | ROM free: issue buffered/direct loader write, else grant a pending drive
  // S_WAIT | fetch for drive g in flight; cnt counts down the ROM latency

  if (NDRV < 1 || NDRV > 4) begin : g_bad_ndrv
    $error("iecdrv_rom_arbiter: NDRV must be 1..4");
  end
  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_lat
    $error("iecdrv_rom_arbiter: ROM_LAT must be 1..3");
  end

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t          state;
  logic [NDRV-1:0] pend;
  logic [AW-1:0]   addr [NDRV];
  logic [1:0]      rr;
  logic [1:0]      g;
  logic [1:0]      cnt;
  logic [1:0]      gnt;
  logic            gnt_v;
  logic            wbuf_v;
  logic [AW-1:0]   wbuf_addr;
  logic [7:0]      wbuf_data;
  logic [NDRV-1:0] hit;
  logic            fetch_done;

  assign fetch_done = (state == S_WAIT) && (cnt == 2'd0);

  // First pending drive at or after rr, wrapping modulo NDRV.
  always_comb begin
    int         idx;
    logic [1:0] idx2;
    idx   = 0;
    idx2  = 2'd0;
    gnt   = 2'd0;
    gnt_v = 1'b0;
    for (int k = NDRV - 1; k >= 0; k--) begin
      idx = int'(rr) + k;
      if (idx >= NDRV) idx = idx - NDRV;
      idx2 = idx[1:0];
      if (pend[idx2]) begin
        gnt   = idx2;
        gnt_v = 1'b1;
      end
    end
  end

  always_comb begin
    busy = pend;
    if (state == S_WAIT) busy[g] = 1'b1;
  end

`ifdef IECDRV_ROM_HITCACHE_EN
  logic [AW-1:0]   last_addr [NDRV];
  logic [NDRV-1:0] hit_ok;

  always_comb begin
    hit = '0;
    for (int i = 0; i < NDRV; i++)
      hit[i] = req[i] & hit_ok[i] & (req_addr[i*AW +: AW] == last_addr[i]);
  end

  // A loader write during or right after a fetch may have changed the byte, so it must not seed a hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_ok <= '0;
      for (int i = 0; i < NDRV; i++) last_addr[i] <= '0;
    end else begin
      if (fetch_done) begin
        last_addr[g] <= mem_addr;
        hit_ok[g]    <= ~(ld_wr | wbuf_v);
      end
      if (ld_wr) hit_ok <= '0;
    end
  end
`else
  assign hit = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      pend      <= '0;
      rr        <= 2'd0;
      g         <= 2'd0;
      cnt       <= 2'd0;
      wbuf_v    <= 1'b0;
      wbuf_addr <= '0;
      wbuf_data <= 8'h00;
      rd_data   <= {NDRV{8'hFF}};
      rd_valid  <= '0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_d     <= 8'h00;
      for (int i = 0; i < NDRV; i++) addr[i] <= '0;
    end else begin
      rd_valid <= hit;
      mem_we   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (wbuf_v) begin
            mem_we   <= 1'b1;
            mem_addr <= wbuf_addr;
            mem_d    <= wbuf_data;
            wbuf_v   <= 1'b0;
            if (ld_wr) begin
              wbuf_v    <= 1'b1;
              wbuf_addr <= ld_addr;
              wbuf_data <= ld_data;
            end
          end else if (ld_wr) begin
            mem_we   <= 1'b1;
            mem_addr <= ld_addr;
            mem_d    <= ld_data;
          end else if (gnt_v) begin
            mem_addr   <= addr[gnt];
            pend[gnt]  <= 1'b0;
            g          <= gnt;
            rr         <= (int'(gnt) == NDRV - 1) ? 2'd0 : gnt + 2'd1;
            cnt        <= 2'(ROM_LAT);
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (ld_wr) begin
            wbuf_v    <= 1'b1;
            wbuf_addr <= ld_addr;
            wbuf_data <= ld_data;
          end
          if (cnt == 2'd0) begin
            rd_data[int'(g)*8 +: 8] <= mem_q;
            rd_valid[g]             <= 1'b1;
            state                   <= S_IDLE;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase

      // A new request wins over the grant clearing its pend bit.
      for (int i = 0; i < NDRV; i++) begin
        if (req[i] && !hit[i]) begin
          pend[i] <= 1'b1;
          addr[i] <= req_addr[i*AW +: AW];
        end
      end
    end
  end

endmodule

// File: tb/tb_iecdrv_rom_arbiter.sv
// Directed testbench for iecdrv_rom_arbiter (NDRV=4, AW=15, ROM_LAT=1) with a behavioural synchronous ROM.
module tb_iecdrv_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [59:0] req_addr;
  logic [31:0] rd_data;
  logic [3:0]  rd_valid;
  logic [3:0]  busy;
  logic        ld_wr;
  logic [14:0] ld_addr;
  logic [7:0]  ld_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_d;
  logic [7:0]  mem_q;

  logic [7:0] rom [0:32767];

  int checks = 0;
  int errors = 0;

  int got_n;
  int got_ord [4];
  int got_lat [4];
  int got_dat [4];

  iecdrv_rom_arbiter #(.NDRV(4), .AW(15), .ROM_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) rom[mem_addr] <= mem_d;
    mem_q <= rom[mem_addr];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    req   = '0;
    ld_wr = 1'b0;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // Pulses req[drv] and returns the number of edges until rd_valid[drv] (-1 on timeout).
  task automatic run_fetch(input int drv, input logic [14:0] a, output int lat);
    lat = -1;
    req_addr[drv*15 +: 15] = a;
    req[drv] = 1'b1;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      tick;
      req[drv] = 1'b0;
      if (rd_valid[drv]) lat = n;
    end
  endtask

  // With req already driven, records the order, latency and data of completions.
  task automatic collect(input int budget);
    got_n = 0;
    for (int k = 0; k < 4; k++) begin
      got_ord[k] = -1; got_lat[k] = -1; got_dat[k] = -1;
    end
    for (int n = 1; n <= budget; n++) begin
      tick;
      req = '0;
      for (int d = 0; d < 4; d++) begin
        if (rd_valid[d] && got_n < 4) begin
          got_ord[got_n] = d;
          got_lat[got_n] = n;
          got_dat[got_n] = int'(rd_data[d*8 +: 8]);
          got_n++;
        end
      end
    end
  endtask

  task automatic test_reset;
    do_reset;
    checks++; if (rd_data !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_rd_data: got %h expected FFFFFFFF", rd_data); end
    checks++; if (rd_valid !== 4'b0000) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0000", rd_valid); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL reset_busy: got %b expected 0000", busy); end
    checks++; if (mem_addr !== 15'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0000", mem_addr); end
    checks++; if (mem_we !== 1'b0 || mem_d !== 8'h00) begin errors++; $display("FAIL reset_mem_wr: got we=%b d=%h expected we=0 d=00", mem_we, mem_d); end
  endtask

  task automatic test_single_fetch;
    int lat;
    lat = -1;
    do_reset;
    req_addr[14:0] = 15'h7FFC;
    req[0] = 1'b1;
    tick;
    req[0] = 1'b0;
    checks++; if (busy !== 4'b0001) begin errors++; $display("FAIL single_busy_pending: got %b expected 0001", busy); end
    if (rd_valid[0]) lat = 1;
    for (int n = 2; n <= 20 && lat < 0; n++) begin
      tick;
      if (rd_valid[0]) lat = n;
    end
    checks++; if (lat !== 4) begin errors++; $display("FAIL single_latency: got %0d expected 4", lat); end
    checks++; if (rd_data[7:0] !== 8'hA0) begin errors++; $display("FAIL single_data: got %h expected A0", rd_data[7:0]); end
    checks++; if (mem_addr !== 15'h7FFC) begin errors++; $display("FAIL single_mem_addr: got %h expected 7FFC", mem_addr); end
    checks++; if (busy !== 4'b0000) begin errors++; $display("FAIL single_busy_done: got %b expected 0000", busy); end
  endtask

  task automatic test_simultaneous;
    int exp_dat [4];
    exp_dat = '{32'h5A, 32'h5B, 32'h58, 32'h59};
    do_reset;
    for (int d = 0; d < 4; d++) req_addr[d*15 +: 15] = 15'(d);
    req = 4'b1111;
    collect(18);
    checks++; if (got_n !== 4) begin errors++; $display("FAIL simul_count: got %0d expected 4", got_n); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (got_ord[k] !== k || got_lat[k] !== 4 + 3*k || got_dat[k] !== exp_dat[k]) begin
        errors++;
        $display("FAIL simul_slot%0d: got drv=%0d lat=%0d data=%h expected drv=%0d lat=%0d data=%h",
                 k, got_ord[k], got_lat[k], got_dat[k], k, 4 + 3*k, exp_dat[k]);
      end
    end
  endtask

  task automatic test_round_robin;
    int lat;
    do_reset;
    run_fetch(2, 15'h0002, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL rr_first_latency: got %0d expected 4", lat); end
    req_addr[0 +: 15]  = 15'h0000;
    req_addr[30 +: 15] = 15'h0001;
    req = 4'b0101;
    collect(10);
    checks++;
    if (got_n !== 2 || got_ord[0] !== 0 || got_ord[1] !== 2 || got_dat[0] !== 32'h5A || got_dat[1] !== 32'h5B) begin
      errors++;
      $display("FAIL rr_wrap: got n=%0d order=%0d,%0d data=%h,%h expected n=2 order=0,2 data=5a,5b",
               got_n, got_ord[0], got_ord[1], got_dat[0], got_dat[1]);
    end
    req_addr[15 +: 15] = 15'h0003;
    req_addr[45 +: 15] = 15'h0030;
    req = 4'b1010;
    collect(10);
    checks++;
    if (got_n !== 2 || got_ord[0] !== 3 || got_ord[1] !== 1 || got_dat[0] !== 32'h31 || got_dat[1] !== 32'h59) begin
      errors++;
      $display("FAIL rr_rotate: got n=%0d order=%0d,%0d data=%h,%h expected n=2 order=3,1 data=31,59",
               got_n, got_ord[0], got_ord[1], got_dat[0], got_dat[1]);
    end
  endtask

  task automatic test_loader;
    int we_edge, g3_edge, v1, v3, lat;
    logic [14:0] we_a;
    logic [7:0]  we_d, d1, d3;
    we_edge = -1; g3_edge = -1; v1 = -1; v3 = -1;
    we_a = '0; we_d = '0; d1 = '0; d3 = '0;
    do_reset;
    req_addr[15 +: 15] = 15'h0020;
    req_addr[45 +: 15] = 15'h0030;
    req = 4'b1010;
    for (int n = 1; n <= 20; n++) begin
      tick;
      if (n == 1) req = '0;
      if (mem_we && we_edge < 0) begin we_edge = n; we_a = mem_addr; we_d = mem_d; end
      if (!mem_we && mem_addr == 15'h0030 && g3_edge < 0) g3_edge = n;
      if (rd_valid[1] && v1 < 0) begin v1 = n; d1 = rd_data[15:8]; end
      if (rd_valid[3] && v3 < 0) begin v3 = n; d3 = rd_data[31:24]; end
      if (n == 2) begin ld_addr = 15'h0010; ld_data = 8'h55; ld_wr = 1'b1; end
      if (n == 3) ld_wr = 1'b0;
    end
    checks++; if (v1 !== 4 || d1 !== 8'h21) begin errors++; $display("FAIL loader_drv1: got edge=%0d data=%h expected edge=4 data=21", v1, d1); end
    checks++; if (we_edge !== 5 || we_a !== 15'h0010 || we_d !== 8'h55) begin errors++; $display("FAIL loader_write: got edge=%0d addr=%h data=%h expected edge=5 addr=0010 data=55", we_edge, we_a, we_d); end
    checks++; if (g3_edge !== 6) begin errors++; $display("FAIL loader_grant3: got edge=%0d expected 6", g3_edge); end
    checks++; if (v3 !== 8 || d3 !== 8'h31) begin errors++; $display("FAIL loader_drv3: got edge=%0d data=%h expected edge=8 data=31", v3, d3); end
    run_fetch(0, 15'h0010, lat);
    checks++; if (lat !== 4 || rd_data[7:0] !== 8'h55) begin errors++; $display("FAIL loader_readback: got lat=%0d data=%h expected lat=4 data=55", lat, rd_data[7:0]); end
    ld_addr = 15'h0040; ld_data = 8'h77; ld_wr = 1'b1;
    tick;
    ld_wr = 1'b0;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 15'h0040 || mem_d !== 8'h77) begin errors++; $display("FAIL loader_idle_write: got we=%b addr=%h d=%h expected we=1 addr=0040 d=77", mem_we, mem_addr, mem_d); end
    tick;
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL loader_we_pulse: got %b expected 0", mem_we); end
  endtask

  task automatic test_reset_mid_fetch;
    int lat, stray;
    stray = 0;
    do_reset;
    run_fetch(2, 15'h0003, lat);
    checks++; if (lat !== 4 || rd_data[23:16] !== 8'h59) begin errors++; $display("FAIL rmid_prefetch: got lat=%0d data=%h expected lat=4 data=59", lat, rd_data[23:16]); end
    req_addr[30 +: 15] = 15'h0001;
    req[2] = 1'b1;
    tick;
    req[2] = 1'b0;
    tick;
    checks++; if (busy !== 4'b0100) begin errors++; $display("FAIL rmid_inflight: got %b expected 0100", busy); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    checks++; if (rd_valid !== 4'b0000 || busy !== 4'b0000) begin errors++; $display("FAIL rmid_flags: got valid=%b busy=%b expected 0000 0000", rd_valid, busy); end
    checks++; if (rd_data[23:16] !== 8'hFF) begin errors++; $display("FAIL rmid_data: got %h expected FF", rd_data[23:16]); end
    for (int n = 0; n < 6; n++) begin
      tick;
      if (rd_valid !== 4'b0000) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL rmid_stray_valid: got %0d pulses expected 0", stray); end
    run_fetch(2, 15'h0002, lat);
    checks++; if (lat !== 4 || rd_data[23:16] !== 8'h58) begin errors++; $display("FAIL rmid_after: got lat=%0d data=%h expected lat=4 data=58", lat, rd_data[23:16]); end
  endtask

  task automatic test_hitcache;
    int lat;
    int exp_lat;
    logic [14:0] exp_ma;
`ifdef IECDRV_ROM_HITCACHE_EN
    exp_lat = 1;
    exp_ma  = 15'h0003;
`else
    exp_lat = 4;
    exp_ma  = 15'h1234;
`endif
    do_reset;
    run_fetch(1, 15'h1234, lat);
    checks++; if (lat !== 4 || rd_data[15:8] !== 8'hC3) begin errors++; $display("FAIL hit_first: got lat=%0d data=%h expected lat=4 data=C3", lat, rd_data[15:8]); end
    run_fetch(0, 15'h0003, lat);
    checks++; if (lat !== 4 || rd_data[7:0] !== 8'h59) begin errors++; $display("FAIL hit_other: got lat=%0d data=%h expected lat=4 data=59", lat, rd_data[7:0]); end
    run_fetch(1, 15'h1234, lat);
    checks++; if (lat !== exp_lat) begin errors++; $display("FAIL hit_repeat_latency: got %0d expected %0d", lat, exp_lat); end
    checks++; if (mem_addr !== exp_ma || rd_data[15:8] !== 8'hC3) begin errors++; $display("FAIL hit_repeat_mem: got addr=%h data=%h expected addr=%h data=C3", mem_addr, rd_data[15:8], exp_ma); end
    ld_addr = 15'h0050; ld_data = 8'h11; ld_wr = 1'b1;
    tick;
    ld_wr = 1'b0;
    tick;
    run_fetch(1, 15'h1234, lat);
    checks++; if (lat !== 4 || mem_addr !== 15'h1234) begin errors++; $display("FAIL hit_after_load: got lat=%0d addr=%h expected lat=4 addr=1234", lat, mem_addr); end
  endtask

  initial begin
    reset = 1'b1; req = '0; req_addr = '0;
    ld_wr = 1'b0; ld_addr = '0; ld_data = '0;
    rom[15'h0000] = 8'h5A; rom[15'h0001] = 8'h5B;
    rom[15'h0002] = 8'h58; rom[15'h0003] = 8'h59;
    rom[15'h0010] = 8'h10; rom[15'h0020] = 8'h21;
    rom[15'h0030] = 8'h31; rom[15'h0040] = 8'h40;
    rom[15'h0050] = 8'h50; rom[15'h1234] = 8'hC3;
    rom[15'h7FFC] = 8'hA0;

    test_reset;
    test_single_fetch;
    test_simultaneous;
    test_round_robin;
    test_loader;
    test_reset_mid_fetch;
    test_hitcache;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
